audio_serial_tx: RTL
====================

# audio_serial_tx

Consumer end of the sample stream produced by the looping sample ROMs. It accepts unsigned 8-bit audio samples through a valid/ready handshake into a 4-entry FIFO. It converts each sample to two's complement and serializes it MSB-first as a mono I2S-style frame: the same sample goes in the left and right slots, and the block drives bit clock, word select and serial data. It sits between the sample source and the board audio codec pins.

## Interface
- CLK_DIV, 4: Clk cycles per bit-clock half period; legal range ≥2.
- FIFO_DEPTH, 4: sample FIFO entries; power of two.
- Clk  in  1  system clock; all logic on posedge.
- Reset_n  in  1  asynchronous, active-low reset.
- sample_in  in  8  unsigned offset-binary sample; 0x80 = midscale.
- sample_valid  in  1  sample_in is valid this cycle.
- sample_ready  out  1  FIFO can accept a sample; push happens when valid & ready.
- enable  in  1  run the serializer.
- clear_underrun  in  1  clears the underrun flag.
- bclk  out  1  bit clock.
- lrclk  out  1  word select: 0 = left slot, 1 = right slot.
- sdata  out  1  serial data, MSB first.
- underrun  out  1  sticky flag: a frame started with the FIFO empty.
- fifo_level  out  3  current FIFO occupancy, 0..4.

## Operation
- Reset values:
  - bclk=0, lrclk=0, sdata=0, underrun=0, fifo_level=0, sample_ready=1.
  - FIFO is emptied; divider=0; bit_idx=0; state IDLE.
- FIFO:
  - sample_ready = (fifo_level != FIFO_DEPTH). This is combinational from registered level.
  - Push and pop in the same cycle leave the level unchanged.
  - A pop on an empty FIFO is not performed, even if a push happens in the same cycle. The pushed sample is stored.
  - The FIFO accepts pushes in any state.
- States:
  - IDLE: bclk, lrclk and sdata held at 0; divider held at 0.
    - IDLE→LOAD when enable=1.
  - LOAD (1 cycle): pop the FIFO head into shift_reg as {~s[7], s[6:0]}.
    - If the FIFO is empty, load 0x00 and set underrun.
    - Set bit_idx=0, lrclk=0, sdata=loaded bit 7.
    - →RUN.
  - RUN: divider counts 0..CLK_DIV-1. At CLK_DIV-1 it wraps and bclk toggles.
  - On each bclk falling toggle:
    - bit_idx increments and sdata advances to the next bit.
    - Bit order is bit 7 down to bit 0 for bit_idx 0..7, then the same 8 bits again for bit_idx 8..15.
    - lrclk = bit_idx[3].
  - Falling toggle at bit_idx=15:
    - enable=1: wrap to bit_idx=0 and pop the next sample in the same cycle (same rule as LOAD).
    - enable=0: →IDLE, with outputs driven to IDLE values.
  - enable dropping mid-frame never truncates a frame.
- underrun: set on an empty pop; cleared by clear_underrun. Set wins if both occur in the same cycle.
- Reset_n low at any time: all outputs return to reset values immediately. The frame is abandoned.

## Timing
- bclk period is 2·CLK_DIV Clk cycles; a frame is 32·CLK_DIV cycles (default 8 and 128).
- sdata and lrclk change only in the cycle where bclk goes 1→0, or in LOAD. They are stable across every bclk rising edge.
- Latency, enable 0→1 (sampled at edge N):
  - LOAD at edge N+1.
  - First bclk rise at edge N+1+CLK_DIV.
- Steady-state consumption is one sample per frame. The pop happens on the frame-boundary falling toggle.
- Push-to-ready: a push that fills the FIFO drops sample_ready at the next edge.

## Structure
- Package audio_pkg:
  - SAMPLE_W=8 and FRAME_BITS=16.
  - Function to_twos(logic [7:0]) that inverts the MSB.
  - State enum {IDLE, LOAD, RUN}.
- Sub-module sample_fifo (parameterized depth and width; push/pop/level/full/empty). The serializer FSM, divider and shift register stay in audio_serial_tx.

## Test plan
- enable=0, push 5 samples back-to-back → sample_ready low after the 4th push; fifo_level=4; 5th not accepted.
- Push 0xFF, enable=1, CLK_DIV=4 → sdata bits 0,1,1,1,1,1,1,1 sampled on bclk rises, twice; lrclk 0 for the first 8 and 1 for the next 8; frame = 128 cycles.
- Push 0x80 then 0x00 → frame 1 is all zeros; frame 2 is 1,0,0,0,0,0,0,0 per slot; underrun stays 0.
- Empty FIFO, enable=1 → all-zero frame; underrun=1 after LOAD; a clear_underrun pulse returns it to 0.
- Drop enable at bit_idx=3 → frame completes to bit 15, then IDLE with bclk=lrclk=sdata=0; the next FIFO entry is not popped.
- Assert Reset_n=0 mid-frame with 3 queued samples → outputs reset at once; fifo_level=0 and sample_ready=1.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and constants for the mono I2S-style sample serializer.
package audio_pkg;

    localparam int SAMPLE_W   = 8;
    localparam int FRAME_BITS = 16;
    localparam int BIT_IDX_W  = $clog2(FRAME_BITS);
    localparam int SLOT_W     = $clog2(SAMPLE_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Offset-binary to two's complement: flipping the MSB subtracts midscale.
    function automatic logic [SAMPLE_W-1:0] to_twos(input logic [SAMPLE_W-1:0] s);
        return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
    endfunction

endpackage

// File: rtl/audio_serial_tx_if.sv
// Valid/ready sample bus between the sample source and the serializer.
interface audio_serial_tx_if;
    import audio_pkg::*;

    logic [SAMPLE_W-1:0] sample_in;
    logic                sample_valid;
    logic                sample_ready;

    modport master (
        output sample_in,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_in,
        input  sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/sample_fifo.sv
// Small register-based FIFO; head data is visible combinationally so it can be popped
// and consumed in the same cycle.
module sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push && !full;
    // A pop on an empty FIFO is dropped even if a push lands in the same cycle.
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign level   = level_q;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign mem_d[gi] = (do_push && (wr_ptr_q == PTR_W'(gi))) ? wdata : mem_q[gi];
        end
    endgenerate

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (!do_push && do_pop) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/audio_serial_tx.sv
// Buffers unsigned samples and serializes each one MSB-first into both slots of an
// I2S-style frame, generating bclk/lrclk/sdata from the system clock.
module audio_serial_tx
    import audio_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              Clk,
    input  logic                              Reset_n,
    audio_serial_tx_if.slave                  sample_bus,
    input  logic                              enable,
    input  logic                              clear_underrun,
    output logic                              bclk,
    output logic                              lrclk,
    output logic                              sdata,
    output logic                              underrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [SAMPLE_W-1:0]  fifo_rdata;
    logic [LVL_W-1:0]     fifo_level_w;
    logic [SAMPLE_W-1:0]  load_word;

    state_t               state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [BIT_IDX_W-1:0] next_idx;
    logic [SAMPLE_W-1:0]  shift_q, shift_d;
    logic                 bclk_q, bclk_d;
    logic                 lrclk_q, lrclk_d;
    logic                 sdata_q, sdata_d;
    logic                 underrun_q, underrun_d;
    logic                 bit_tick;

    assign sample_bus.sample_ready = !fifo_full;
    assign fifo_push               = sample_bus.sample_valid && sample_bus.sample_ready;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wdata   (sample_bus.sample_in),
        .rdata   (fifo_rdata),
        .level   (fifo_level_w),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // An empty FIFO yields a silent (all-zero) frame rather than a stale sample.
    assign load_word = fifo_empty ? '0 : to_twos(fifo_rdata);
    assign bit_tick  = (div_q == DIV_W'(CLK_DIV - 1));
    assign next_idx  = bit_idx_q + BIT_IDX_W'(1);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        bclk_d    = bclk_q;
        lrclk_d   = lrclk_q;
        sdata_d   = sdata_q;
        fifo_pop  = 1'b0;

        case (state_q)
            IDLE: begin
                div_d     = '0;
                bit_idx_d = '0;
                bclk_d    = 1'b0;
                lrclk_d   = 1'b0;
                sdata_d   = 1'b0;
                if (enable) begin
                    state_d = LOAD;
                end
            end

            LOAD: begin
                fifo_pop  = 1'b1;
                shift_d   = load_word;
                bit_idx_d = '0;
                div_d     = '0;
                bclk_d    = 1'b0;
                lrclk_d   = 1'b0;
                sdata_d   = load_word[SAMPLE_W-1];
                state_d   = RUN;
            end

            RUN: begin
                if (!bit_tick) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d  = '0;
                    bclk_d = !bclk_q;
                    // Data and word select only move on the falling toggle.
                    if (bclk_q) begin
                        if (bit_idx_q == BIT_IDX_W'(FRAME_BITS - 1)) begin
                            if (enable) begin
                                fifo_pop  = 1'b1;
                                shift_d   = load_word;
                                bit_idx_d = '0;
                                lrclk_d   = 1'b0;
                                sdata_d   = load_word[SAMPLE_W-1];
                            end else begin
                                state_d   = IDLE;
                                bit_idx_d = '0;
                                lrclk_d   = 1'b0;
                                sdata_d   = 1'b0;
                            end
                        end else begin
                            bit_idx_d = next_idx;
                            lrclk_d   = next_idx[BIT_IDX_W-1];
                            sdata_d   = shift_q[SLOT_W'(SAMPLE_W - 1) - next_idx[SLOT_W-1:0]];
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        underrun_d = underrun_q;
        if (clear_underrun) begin
            underrun_d = 1'b0;
        end
        if (fifo_pop && fifo_empty) begin
            underrun_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            bclk_q     <= bclk_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            underrun_q <= underrun_d;
        end
    end

    assign bclk       = bclk_q;
    assign lrclk      = lrclk_q;
    assign sdata      = sdata_q;
    assign underrun   = underrun_q;
    assign fifo_level = fifo_level_w;

endmodule
